// File: rtl/pool_pkg.sv
// Shared constants and types for the 2x2 pooling window former.
package pool_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_CH = 32;

  // Sub-sample slot order inside each channel's 4*DW window.
  localparam int WIN_R0C0 = 0;
  localparam int WIN_R0C1 = 1;
  localparam int WIN_R1C0 = 2;
  localparam int WIN_R1C1 = 3;

  typedef logic [DEF_CH*DEF_DW-1:0] pix_t;

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-in / window-out bus for pool_window_gen.
// sof_in/sof_err exist only when POOL_WIN_SOF_EN is defined.
interface pool_window_gen_if
  import pool_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int DW = DEF_DW
);

  logic                 valid_in;
  logic [CH*DW-1:0]     data_in;
  logic [CH*4*DW-1:0]   win_out;
  logic                 valid_out;
  logic                 frame_done;
`ifdef POOL_WIN_SOF_EN
  logic                 sof_in;
  logic                 sof_err;
`endif

  modport master (
`ifdef POOL_WIN_SOF_EN
    output sof_in,
    input  sof_err,
`endif
    output valid_in, data_in,
    input  win_out, valid_out, frame_done
  );

  modport slave (
`ifdef POOL_WIN_SOF_EN
    input  sof_in,
    output sof_err,
`endif
    input  valid_in, data_in,
    output win_out, valid_out, frame_done
  );

endinterface

// File: rtl/pool_line_buf.sv
// One-row pixel store: single write port, combinational read port.
// Contents are intentionally not reset; every entry is written before it is read.
module pool_line_buf #(
  parameter int DEPTH = 24,
  parameter int WIDTH = 1024,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 / stride-2 window former feeding the max-pooling stage.
// Optional start-of-frame resync is enabled with `define POOL_WIN_SOF_EN.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int CH    = DEF_CH,
  parameter int DW    = DEF_DW
) (
  input logic               clk,
  input logic               rst_n,
  pool_window_gen_if.slave  io_bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = CH*DW;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H-1);
  localparam logic [CW:0]   COL_LIMIT = (CW+1)'(2*(IMG_W/2));
  localparam logic [RW:0]   ROW_LIMIT = (RW+1)'(2*(IMG_H/2));

  logic [CW-1:0]      r_col, w_col;
  logic [RW-1:0]      r_row, w_row;
  logic [PW-1:0]      r_curPrev, r_upPrev, w_upRd;
  logic [CH*4*DW-1:0] r_win, w_win;
  logic               r_validOut, r_frameDone;
  logic               w_sof, w_oddRow, w_wrEn, w_emit, w_lastPix;

`ifdef POOL_WIN_SOF_EN
  logic r_sofErr;
  assign w_sof = io_bus.valid_in & io_bus.sof_in;
`else
  assign w_sof = 1'b0;
`endif

  // A start-of-frame pixel is handled as (0,0) regardless of where the counters sit.
  assign w_col     = w_sof ? '0 : r_col;
  assign w_row     = w_sof ? '0 : r_row;
  assign w_oddRow  = w_row[0];
  assign w_wrEn    = io_bus.valid_in & ~w_oddRow;
  assign w_lastPix = (w_col == COL_LAST) & (w_row == ROW_LAST);
  assign w_emit    = io_bus.valid_in & w_oddRow & w_col[0]
                   & ({1'b0, w_col} < COL_LIMIT) & ({1'b0, w_row} < ROW_LIMIT);

  pool_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PW),
    .AW    (CW)
  ) u_lineBuf (
    .clk     (clk),
    .i_we    (w_wrEn),
    .i_waddr (w_col),
    .i_wdata (io_bus.data_in),
    .i_raddr (w_col),
    .o_rdata (w_upRd)
  );

  always_comb begin
    w_win = '0;
    for (int c = 0; c < CH; c++) begin
      w_win[c*4*DW + WIN_R0C0*DW +: DW] = r_upPrev[c*DW +: DW];
      w_win[c*4*DW + WIN_R0C1*DW +: DW] = w_upRd[c*DW +: DW];
      w_win[c*4*DW + WIN_R1C0*DW +: DW] = r_curPrev[c*DW +: DW];
      w_win[c*4*DW + WIN_R1C1*DW +: DW] = io_bus.data_in[c*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (io_bus.valid_in) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_validOut  <= 1'b0;
      r_frameDone <= 1'b0;
      r_win       <= '0;
      r_curPrev   <= '0;
      r_upPrev    <= '0;
    end else begin
      r_validOut  <= w_emit;
      r_frameDone <= io_bus.valid_in & w_lastPix;
      if (w_emit) r_win <= w_win;
      if (io_bus.valid_in & w_oddRow) begin
        r_curPrev <= io_bus.data_in;
        r_upPrev  <= w_upRd;
      end
    end
  end

`ifdef POOL_WIN_SOF_EN
  // Sticky: a resync that lands anywhere but the natural frame origin is a misalignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_sofErr <= 1'b0;
    else if (w_sof && (r_col != '0 || r_row != '0)) r_sofErr <= 1'b1;
  end
  assign io_bus.sof_err = r_sofErr;
`endif

  assign io_bus.win_out    = r_win;
  assign io_bus.valid_out  = r_validOut;
  assign io_bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen: a 4x4 and a 5x5 instance checked every
// cycle against a coordinate-level model, plus hand-computed window literals.
module tb_pool_window_gen;
  import pool_pkg::*;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int PW = CH*DW;
  localparam int WW = CH*4*DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_window_gen_if #(.CH(CH), .DW(DW)) busA ();
  pool_window_gen_if #(.CH(CH), .DW(DW)) busB ();

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .CH(CH), .DW(DW)) dutA (
    .clk(clk), .rst_n(rst_n), .io_bus(busA));
  pool_window_gen #(.IMG_W(5), .IMG_H(5), .CH(CH), .DW(DW)) dutB (
    .clk(clk), .rst_n(rst_n), .io_bus(busB));

  logic [WW-1:0] winOut [2];
  logic          validOut [2];
  logic          frameDone [2];
  assign winOut[0] = busA.win_out;    assign winOut[1] = busB.win_out;
  assign validOut[0] = busA.valid_out; assign validOut[1] = busB.valid_out;
  assign frameDone[0] = busA.frame_done; assign frameDone[1] = busB.frame_done;
`ifdef POOL_WIN_SOF_EN
  logic sofErr [2];
  assign sofErr[0] = busA.sof_err;   assign sofErr[1] = busB.sof_err;
`endif

  // Model state: image pixels placed by frame position, expected outputs per DUT.
  logic [15:0]   img [2][8][8];
  int            posIdx [2];
  logic [WW-1:0] lastWin [2];
  logic          expV [2], expD [2], expE [2];
  logic          dueV [2], dueD [2], dueE [2];
  logic [WW-1:0] dueW [2];
  logic [63:0]   capQ [2][$];
  logic [63:0]   modelQ [2][$];
  int            doneCnt [2];
  int            checks = 0;
  int            errors = 0;
  bit            started = 0;

  function automatic int dimOf(input int sel);
    return (sel == 0) ? 4 : 5;
  endfunction

  function automatic logic [PW-1:0] chanData(input logic [15:0] pix);
    return {pix ^ 16'hA5A5, pix};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelAccept(input int sel, input logic [15:0] pix, input bit sof);
    int r, c, w, h, pr, pc;
    logic [WW-1:0] win;
    logic [PW-1:0] d;
    w = dimOf(sel);
    h = dimOf(sel);
    if (sof) begin
      if (posIdx[sel] != 0) expE[sel] = 1'b1;
      posIdx[sel] = 0;
    end
    r = posIdx[sel] / w;
    c = posIdx[sel] % w;
    img[sel][r][c] = pix;
    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2*(h/2)) && (c < 2*(w/2))) begin
      win = '0;
      for (int ch = 0; ch < CH; ch++)
        for (int k = 0; k < 4; k++) begin
          pr = r - 1 + k/2;
          pc = c - 1 + k%2;
          d  = chanData(img[sel][pr][pc]);
          win[ch*4*DW + k*DW +: DW] = d[ch*DW +: DW];
        end
      lastWin[sel] = win;
      modelQ[sel].push_back(win[63:0]);
      expV[sel] = 1'b1;
    end
    if (r == h-1 && c == w-1) expD[sel] = 1'b1;
    posIdx[sel] = (posIdx[sel] + 1) % (w*h);
  endtask

  task automatic applyStimulus(input int sel, input bit v, input logic [15:0] pix, input bit sof);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      expV[i] = 1'b0;
      expD[i] = 1'b0;
    end
    busA.valid_in = 1'b0;
    busB.valid_in = 1'b0;
`ifdef POOL_WIN_SOF_EN
    busA.sof_in = 1'b0;
    busB.sof_in = 1'b0;
`endif
    if (v) begin
      if (sel == 0) begin
        busA.valid_in = 1'b1;
        busA.data_in  = chanData(pix);
`ifdef POOL_WIN_SOF_EN
        busA.sof_in   = sof;
`endif
      end else begin
        busB.valid_in = 1'b1;
        busB.data_in  = chanData(pix);
`ifdef POOL_WIN_SOF_EN
        busB.sof_in   = sof;
`endif
      end
      modelAccept(sel, pix, sof);
    end
  endtask

  task automatic sendFrame(input int sel, input logic [15:0] offset, input bit gap, input bit sofFirst);
    for (int r = 0; r < dimOf(sel); r++)
      for (int c = 0; c < dimOf(sel); c++) begin
        applyStimulus(sel, 1'b1, offset + 16'(r*16 + c), sofFirst && r == 0 && c == 0);
        if (gap) applyStimulus(sel, 1'b0, 16'h0, 1'b0);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic clearCaptures();
    for (int i = 0; i < 2; i++) begin
      capQ[i].delete();
      modelQ[i].delete();
      doneCnt[i] = 0;
    end
  endtask

  // Compares four captured and four modelled windows from index 'first' against literals.
  task automatic checkWindows(input int sel, input string tag, input int first, input logic [15:0] base);
    logic [63:0] lit [4];
    logic [63:0] ofs;
    lit[0] = 64'h0011_0010_0001_0000;
    lit[1] = 64'h0013_0012_0003_0002;
    lit[2] = 64'h0031_0030_0021_0020;
    lit[3] = 64'h0033_0032_0023_0022;
    ofs = {4{base}};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s dut win%0d", tag, k), {64'h0, capQ[sel][first+k]}, {64'h0, lit[k] | ofs});
      checkOutput($sformatf("%s model win%0d", tag, k), {64'h0, modelQ[sel][first+k]}, {64'h0, lit[k] | ofs});
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    busA.valid_in = 1'b0;
    busB.valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expV[i] = 1'b0; expD[i] = 1'b0; expE[i] = 1'b0;
      lastWin[i] = '0;
      posIdx[i] = 0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset dut%0d valid_out", i), {127'h0, validOut[i]}, 128'h0);
      checkOutput($sformatf("reset dut%0d win_out", i), winOut[i], 128'h0);
      checkOutput($sformatf("reset dut%0d frame_done", i), {127'h0, frameDone[i]}, 128'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      dueV[i] = rst_n ? expV[i] : 1'b0;
      dueD[i] = rst_n ? expD[i] : 1'b0;
      dueE[i] = rst_n ? expE[i] : 1'b0;
      dueW[i] = rst_n ? lastWin[i] : '0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("dut%0d valid_out", i), {127'h0, validOut[i]}, {127'h0, rst_n ? dueV[i] : 1'b0});
        checkOutput($sformatf("dut%0d win_out", i), winOut[i], rst_n ? dueW[i] : '0);
        checkOutput($sformatf("dut%0d frame_done", i), {127'h0, frameDone[i]}, {127'h0, rst_n ? dueD[i] : 1'b0});
`ifdef POOL_WIN_SOF_EN
        checkOutput($sformatf("dut%0d sof_err", i), {127'h0, sofErr[i]}, {127'h0, rst_n ? dueE[i] : 1'b0});
`endif
        if (validOut[i] === 1'b1) capQ[i].push_back(winOut[i][63:0]);
        if (frameDone[i] === 1'b1) doneCnt[i]++;
      end
    end
  end

  initial begin
    busA.valid_in = 1'b0; busA.data_in = '0;
    busB.valid_in = 1'b0; busB.data_in = '0;
`ifdef POOL_WIN_SOF_EN
    busA.sof_in = 1'b0;
    busB.sof_in = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      posIdx[i] = 0; lastWin[i] = '0; doneCnt[i] = 0;
      expV[i] = 1'b0; expD[i] = 1'b0; expE[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("por dut%0d valid_out", i), {127'h0, validOut[i]}, 128'h0);
      checkOutput($sformatf("por dut%0d win_out", i), winOut[i], 128'h0);
    end
    rst_n   = 1'b1;
    started = 1;

    $display("[TB] 4x4 continuous frame");
    clearCaptures();
    sendFrame(0, 16'h0, 1'b0, 1'b0);
    idle(2);
    checkOutput("4x4 window count", 128'(capQ[0].size()), 128'd4);
    checkOutput("4x4 frame_done count", 128'(doneCnt[0]), 128'd1);
    checkWindows(0, "4x4", 0, 16'h0);

    $display("[TB] 4x4 frame with valid gaps");
    clearCaptures();
    sendFrame(0, 16'h0, 1'b1, 1'b0);
    idle(2);
    checkOutput("gap window count", 128'(capQ[0].size()), 128'd4);
    checkWindows(0, "gap", 0, 16'h0);

    $display("[TB] 5x5 frame, trailing row/column dropped");
    clearCaptures();
    sendFrame(1, 16'h0, 1'b0, 1'b0);
    idle(2);
    checkOutput("5x5 window count", 128'(capQ[1].size()), 128'd4);
    checkOutput("5x5 frame_done count", 128'(doneCnt[1]), 128'd1);
    checkWindows(1, "5x5", 0, 16'h0);

    $display("[TB] back-to-back frames");
    clearCaptures();
    sendFrame(0, 16'h0, 1'b0, 1'b0);
    sendFrame(0, 16'h0100, 1'b0, 1'b0);
    idle(2);
    checkOutput("b2b window count", 128'(capQ[0].size()), 128'd8);
    checkOutput("b2b frame_done count", 128'(doneCnt[0]), 128'd2);
    checkWindows(0, "b2b first", 0, 16'h0);
    checkWindows(0, "b2b second", 4, 16'h0100);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, (i < 4) ? 16'(i) : 16'h0010, 1'b0);
    doReset();
    clearCaptures();
    sendFrame(0, 16'h0, 1'b0, 1'b0);
    idle(2);
    checkOutput("post-reset window count", 128'(capQ[0].size()), 128'd4);
    checkWindows(0, "post-reset", 0, 16'h0);

`ifdef POOL_WIN_SOF_EN
    $display("[TB] start-of-frame resync");
    clearCaptures();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 16'h0080 + 16'(i), 1'b0);
    sendFrame(0, 16'h0, 1'b0, 1'b1);
    idle(3);
    checkOutput("sof window count", 128'(capQ[0].size()), 128'd4);
    checkOutput("sof frame_done count", 128'(doneCnt[0]), 128'd1);
    checkOutput("sof_err sticky", {127'h0, sofErr[0]}, 128'd1);
    checkWindows(0, "sof", 0, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
